// File: rtl/serial_chunk_adder_pkg.sv
// Shared types for the chunked serial adder: FSM state encoding and counter sizing.
// Pure declarations; no timing or flow-control behaviour of its own.
package serial_chunk_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One spare bit so the index can step past the last chunk without wrapping.
  function automatic int idx_width(input int nchunk);
    return $clog2(nchunk) + 1;
  endfunction

endpackage

// File: rtl/ripple_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells; zero latency.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module ripple_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             ci_i,
  output logic [CHUNK-1:0] s_o,
  output logic             co_o,
  output logic             c_msb_in_o
);

  logic [CHUNK:0] c;

  assign c[0] = ci_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (s_o[i]),
      .co_o (c[i+1])
    );
  end

  assign co_o       = c[CHUNK];
  assign c_msb_in_o = c[CHUNK-1];

endmodule

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/sub, CHUNK bits per clock LSB first; done pulses WIDTH/CHUNK cycles after start.
// start is taken only while ready (idle); requests during a run are dropped, not queued.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state_q;
  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  opb_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  res_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              done_q;

  logic [BW-1:0]     base;
  logic [CHUNK-1:0]  a_chk;
  logic [CHUNK-1:0]  b_chk;
  logic [CHUNK-1:0]  s_chk;
  logic              co_chk;
  logic              cmsb_chk;
  logic              last_chk;
  logic [WIDTH-1:0]  res_d;

  // Base is pinned to 0 while idle, where idx may sit one past the last chunk.
  assign base     = (state_q == RUN) ? BW'(32'(idx_q) * 32'(CHUNK)) : '0;
  assign a_chk    = opa_q[base +: CHUNK];
  assign b_chk    = opb_q[base +: CHUNK];
  assign last_chk = (idx_q == IDXW'(NCHUNK - 1));

  ripple_chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i        (a_chk),
    .b_i        (b_chk),
    .ci_i       (carry_q),
    .s_o        (s_chk),
    .co_o       (co_chk),
    .c_msb_in_o (cmsb_chk)
  );

  always_comb begin
    res_d = res_q;
    res_d[base +: CHUNK] = s_chk;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so cin is replaced by the forced carry.
            opa_q   <= in1;
            opb_q   <= sub ? ~in2 : in2;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= co_chk;
          idx_q   <= idx_q + 1'b1;
          if (last_chk) begin
            sum_q   <= res_d;
            cout_q  <= co_chk;
            ovf_q   <= co_chk ^ cmsb_chk;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
